// File: rtl/ccd_raw_to_rgb_pkg.sv
// Shared defaults and Bayer/luma definitions for the raw-to-RGB demosaic path.
package ccd_raw_to_rgb_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 12;
  localparam int unsigned DEF_COLUMN_WIDTH = 1280;

  // Position within a 2x2 quad, encoded as {Y[0], X[0]}
  typedef enum logic [1:0] {
    BAYER_G1 = 2'b00,
    BAYER_R  = 2'b01,
    BAYER_B  = 2'b10,
    BAYER_G2 = 2'b11
  } bayer_pos_e;

  // Gray = (WR*R + WG*G + WB*B) >> SHIFT
  localparam int unsigned LUMA_WR    = 1;
  localparam int unsigned LUMA_WG    = 2;
  localparam int unsigned LUMA_WB    = 1;
  localparam int unsigned LUMA_SHIFT = 2;

  function automatic bayer_pos_e bayerPos(input logic y0, input logic x0);
    return bayer_pos_e'({y0, x0});
  endfunction

endpackage

// File: rtl/ccd_raw_to_rgb_if.sv
// Raw pixel stream in / RGB pixel stream out of the demosaic stage.
interface ccd_raw_to_rgb_if
  import ccd_raw_to_rgb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] iDATA;
  logic                  iDVAL;
  logic [15:0]           iX_Cont;
  logic [15:0]           iY_Cont;
  logic [DATA_WIDTH-1:0] oRed;
  logic [DATA_WIDTH-1:0] oGreen;
  logic [DATA_WIDTH-1:0] oBlue;
  logic [DATA_WIDTH-1:0] oGray;
  logic [15:0]           oX_Cont;
  logic [15:0]           oY_Cont;
  logic                  oDVAL;

  modport master (
    output iDATA, iDVAL, iX_Cont, iY_Cont,
    input  oRed, oGreen, oBlue, oGray, oX_Cont, oY_Cont, oDVAL
  );

  modport slave (
    input  iDATA, iDVAL, iX_Cont, iY_Cont,
    output oRed, oGreen, oBlue, oGray, oX_Cont, oY_Cont, oDVAL
  );
endinterface

// File: rtl/ccd_raw_to_rgb_line_buffer.sv
// Single-port read-before-write line buffer, one-cycle read latency.
module ccd_line_buffer #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 1280,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  iCLK,
  input  logic                  iEn,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  input  logic [DATA_WIDTH-1:0] iWrData,
  output logic [DATA_WIDTH-1:0] oRdData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read data holds between enables so the caller can resample it later
  always_ff @(posedge iCLK) begin
    if (iEn) begin
      oRdData     <= mem[iAddr];
      mem[iAddr]  <= iWrData;
    end
  end

endmodule

// File: rtl/ccd_raw_to_rgb.sv
// Demosaics each 2x2 Bayer quad (G1 R / B G2) into one RGB + gray pixel.
module ccd_raw_to_rgb
  import ccd_raw_to_rgb_pkg::*;
#(
  parameter int unsigned COLUMN_WIDTH = DEF_COLUMN_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input logic             iCLK,
  input logic             iRST,
  ccd_raw_to_rgb_if.slave ccd
);

  localparam int unsigned AW = (COLUMN_WIDTH > 1) ? $clog2(COLUMN_WIDTH) : 1;

  logic                  accept;
  logic [DATA_WIDTH-1:0] lbRd;
  logic [DATA_WIDTH-1:0] curPix, curPrev, topPrev;
  logic [15:0]           xS1, yS1;
  logic                  completeS1;
  logic [DATA_WIDTH:0]   greenSum;
  logic [DATA_WIDTH+1:0] graySum;
  logic [DATA_WIDTH-1:0] red, green, blue, gray;

  assign accept = ccd.iDVAL && (32'(ccd.iX_Cont) < COLUMN_WIDTH);

  ccd_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (COLUMN_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_lineBuffer (
    .iCLK    (iCLK),
    .iEn     (accept),
    .iAddr   (ccd.iX_Cont[AW-1:0]),
    .iWrData (ccd.iDATA),
    .oRdData (lbRd)
  );

  // Previous-beat pixels shift only on accepted beats, so valid gaps don't break pairing
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      curPix     <= '0;
      curPrev    <= '0;
      topPrev    <= '0;
      xS1        <= '0;
      yS1        <= '0;
      completeS1 <= 1'b0;
    end else begin
      completeS1 <= accept && (bayerPos(ccd.iY_Cont[0], ccd.iX_Cont[0]) == BAYER_G2);
      if (accept) begin
        curPrev <= curPix;
        topPrev <= lbRd;
        curPix  <= ccd.iDATA;
        xS1     <= ccd.iX_Cont;
        yS1     <= ccd.iY_Cont;
      end
    end
  end

  always_comb begin
    red      = lbRd;
    blue     = curPrev;
    greenSum = {1'b0, topPrev} + {1'b0, curPix};
    green    = DATA_WIDTH'(greenSum >> 1);
    graySum  = (DATA_WIDTH+2)'(LUMA_WR * red)
             + (DATA_WIDTH+2)'(LUMA_WG * green)
             + (DATA_WIDTH+2)'(LUMA_WB * blue);
    gray     = DATA_WIDTH'(graySum >> LUMA_SHIFT);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ccd.oRed    <= '0;
      ccd.oGreen  <= '0;
      ccd.oBlue   <= '0;
      ccd.oGray   <= '0;
      ccd.oX_Cont <= '0;
      ccd.oY_Cont <= '0;
      ccd.oDVAL   <= 1'b0;
    end else begin
      ccd.oDVAL <= completeS1;
      if (completeS1) begin
        ccd.oRed    <= red;
        ccd.oGreen  <= green;
        ccd.oBlue   <= blue;
        ccd.oGray   <= gray;
        ccd.oX_Cont <= xS1 >> 1;
        ccd.oY_Cont <= yS1 >> 1;
      end
    end
  end

endmodule

// File: tb/tb_ccd_raw_to_rgb.sv
// Bench for ccd_raw_to_rgb with a 4-column sensor: table vectors plus corner sequences.
module tb_ccd_raw_to_rgb;
  import ccd_raw_to_rgb_pkg::*;

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 12;

  typedef logic [DW-1:0] pix_t;
  typedef logic [4*DW-1:0] quad_t;  // {r, g, b, gray}

  typedef struct {
    quad_t       q;
    logic [15:0] x;
    logic [15:0] y;
    int unsigned due;
  } exp_t;

  typedef struct {
    pix_t        row0[4];
    pix_t        row1[4];
    int unsigned gap;
    quad_t       q[2];
  } vec_t;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        vec[6];

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  ccd_raw_to_rgb_if #(.DATA_WIDTH(DW)) ccd ();

  ccd_raw_to_rgb #(
    .COLUMN_WIDTH (CW),
    .DATA_WIDTH   (DW)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .ccd  (ccd.slave)
  );

  function automatic quad_t mk(input pix_t r, input pix_t g, input pix_t b, input pix_t gy);
    return {r, g, b, gy};
  endfunction

  function automatic quad_t model(input pix_t g1, input pix_t r, input pix_t b, input pix_t g2);
    int unsigned g, y;
    g = (int'(g1) + int'(g2)) / 2;
    y = (int'(r) + 2 * g + int'(b)) / 4;
    return {r, pix_t'(g), b, pix_t'(y)};
  endfunction

  // Scoreboard consumer: every strobe must match the oldest pending expectation
  always @(negedge iCLK) begin
    if (ccd.oDVAL) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe oX=%0d oY=%0d at cycle %0d, required none",
                 ccd.oX_Cont, ccd.oY_Cont, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({ccd.oRed, ccd.oGreen, ccd.oBlue, ccd.oGray, ccd.oX_Cont, ccd.oY_Cont} !== {e.q, e.x, e.y}) begin
          errors++;
          $display("FAIL pixel: got R=%0d G=%0d B=%0d Gray=%0d X=%0d Y=%0d, required R=%0d G=%0d B=%0d Gray=%0d X=%0d Y=%0d",
                   ccd.oRed, ccd.oGreen, ccd.oBlue, ccd.oGray, ccd.oX_Cont, ccd.oY_Cont,
                   e.q[4*DW-1 -: DW], e.q[3*DW-1 -: DW], e.q[2*DW-1 -: DW], e.q[DW-1:0], e.x, e.y);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: strobe at cycle %0d, required cycle %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic pushExp(input quad_t q, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    e.q = q;
    e.x = x;
    e.y = y;
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic beat(input pix_t d, input logic [15:0] x, input logic [15:0] y);
    @(negedge iCLK);
    ccd.iDVAL   = 1'b1;
    ccd.iDATA   = d;
    ccd.iX_Cont = x;
    ccd.iY_Cont = y;
  endtask

  // Invalid cycles carry junk on data/X so gaps are shown to be ignored
  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge iCLK);
      ccd.iDVAL   = 1'b0;
      ccd.iDATA   = pix_t'($urandom);
      ccd.iX_Cont = 16'($urandom_range(0, 3));
    end
  endtask

  task automatic sendRow(input pix_t px[4], input logic [15:0] y, input int unsigned gap,
                         input bit push, input quad_t q[2]);
    for (int x = 0; x < 4; x++) begin
      beat(px[x], 16'(x), y);
      if (push && y[0] && (x % 2 == 1)) pushExp(q[x/2], 16'(x/2), y >> 1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic sendPair(input pix_t top[4], input pix_t bot[4], input logic [15:0] y,
                          input int unsigned gap);
    quad_t q[2];
    q[0] = model(top[0], top[1], bot[0], bot[1]);
    q[1] = model(top[2], top[3], bot[2], bot[3]);
    sendRow(top, y, gap, 1'b0, q);
    sendRow(bot, y + 16'd1, gap, 1'b1, q);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      idle(1);
      n++;
    end
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d strobes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    pix_t  a0[4], a1[4], a2[4], a3[4], b0[4], b1[4];
    quad_t qa[2];

    vec[0].row0 = '{100, 200, 100, 200}; vec[0].row1 = '{50, 120, 50, 120}; vec[0].gap = 0;
    vec[0].q    = '{mk(200, 110, 50, 117), mk(200, 110, 50, 117)};
    vec[1].row0 = '{100, 200, 100, 200}; vec[1].row1 = '{50, 120, 50, 120}; vec[1].gap = 3;
    vec[1].q    = '{mk(200, 110, 50, 117), mk(200, 110, 50, 117)};
    vec[2].row0 = '{4095, 4095, 4095, 4095}; vec[2].row1 = '{4095, 4095, 4095, 4095}; vec[2].gap = 0;
    vec[2].q    = '{mk(4095, 4095, 4095, 4095), mk(4095, 4095, 4095, 4095)};
    vec[3].row0 = '{0, 0, 0, 0}; vec[3].row1 = '{0, 0, 0, 0}; vec[3].gap = 1;
    vec[3].q    = '{mk(0, 0, 0, 0), mk(0, 0, 0, 0)};
    vec[4].row0 = '{1, 10, 2, 20}; vec[4].row1 = '{30, 4, 40, 7}; vec[4].gap = 0;
    vec[4].q    = '{mk(10, 2, 30, 11), mk(20, 4, 40, 17)};
    vec[5].row0 = '{4095, 4095, 4094, 1}; vec[5].row1 = '{4095, 4095, 1, 4094}; vec[5].gap = 2;
    vec[5].q    = '{mk(4095, 4095, 4095, 4095), mk(1, 4094, 1, 2047)};

    ccd.iDVAL = 1'b0; ccd.iDATA = '0; ccd.iX_Cont = '0; ccd.iY_Cont = '0;
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({ccd.oRed, ccd.oGreen, ccd.oBlue, ccd.oGray, ccd.oX_Cont, ccd.oY_Cont, ccd.oDVAL} !== '0) begin
      errors++;
      $display("FAIL reset_state: got R=%0d G=%0d B=%0d Gray=%0d X=%0d Y=%0d DVAL=%0b, required all 0",
               ccd.oRed, ccd.oGreen, ccd.oBlue, ccd.oGray, ccd.oX_Cont, ccd.oY_Cont, ccd.oDVAL);
    end
    iRST = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      sendRow(vec[i].row0, 16'd0, vec[i].gap, 1'b0, vec[i].q);
      sendRow(vec[i].row1, 16'd1, vec[i].gap, 1'b1, vec[i].q);
      drain("table");
    end

    // Out-of-range X beats alias to addresses 0/1 if wrongly written, and sit between paired beats
    qa[0] = model(100, 200, 50, 120);
    beat(100, 0, 0); beat(999, 4, 0); beat(200, 1, 0); beat(100, 2, 0); beat(200, 3, 0); beat(888, 5, 0);
    beat(50, 0, 1); beat(3333, 4, 1); beat(120, 1, 1); pushExp(qa[0], 0, 0);
    beat(50, 2, 1); beat(3000, 5, 1); beat(120, 3, 1); pushExp(qa[0], 1, 0);
    drain("out_of_range");

    // Reset one cycle after a completing beat whose strobe must never appear
    beat(100, 0, 0); beat(200, 1, 0); beat(100, 2, 0); beat(200, 3, 0);
    beat(50, 0, 1); beat(120, 1, 1);
    @(negedge iCLK);
    ccd.iDVAL = 1'b0;
    iRST = 1'b0;
    #1;
    checks++;
    if ({ccd.oRed, ccd.oGreen, ccd.oBlue, ccd.oGray, ccd.oX_Cont, ccd.oY_Cont, ccd.oDVAL} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got R=%0d G=%0d B=%0d Gray=%0d X=%0d Y=%0d DVAL=%0b, required all 0",
               ccd.oRed, ccd.oGreen, ccd.oBlue, ccd.oGray, ccd.oX_Cont, ccd.oY_Cont, ccd.oDVAL);
    end
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    idle(4);
    sendRow(vec[0].row0, 16'd0, 0, 1'b0, vec[0].q);
    sendRow(vec[0].row1, 16'd1, 0, 1'b1, vec[0].q);
    drain("after_reset");

    // Four-row frame followed directly by a two-row frame with new row-0 data
    a0 = '{10, 20, 30, 40};       a1 = '{50, 60, 70, 80};
    a2 = '{1000, 2000, 3000, 4000}; a3 = '{5, 6, 7, 8};
    b0 = '{400, 500, 600, 700};   b1 = '{11, 22, 33, 44};
    sendPair(a0, a1, 16'd0, 0);
    sendPair(a2, a3, 16'd2, 0);
    sendPair(b0, b1, 16'd0, 0);
    drain("two_frames");

    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_raw_to_rgb.md
Name: ccd_raw_to_rgb

Overview:
Downstream neighbour of the CCD capture stage. Consumes the 12-bit raw Bayer pixel stream plus its X/Y counters and valid, and demosaics each 2x2 Bayer quad (G1 R / B G2) into one RGB pixel plus a luma (gray) value. Output is half resolution in both axes and feeds the iris-segmentation front end.
Uses one line buffer holding the previous sensor row.

Parameters:
COLUMN_WIDTH, 1280, sensor pixels per row; line buffer depth; legal X range 0..COLUMN_WIDTH-1
DATA_WIDTH, 12, raw and colour component width

Ports:
iCLK  in  1  clock; all logic on rising edge
iRST  in  1  asynchronous, active-low reset
iDATA  in  DATA_WIDTH  raw Bayer pixel
iDVAL  in  1  iDATA/iX_Cont/iY_Cont valid this cycle
iX_Cont  in  16  column of current pixel
iY_Cont  in  16  row of current pixel
oRed  out  DATA_WIDTH  red component
oGreen  out  DATA_WIDTH  averaged green component
oBlue  out  DATA_WIDTH  blue component
oGray  out  DATA_WIDTH  luma (R+2G+B)/4
oX_Cont  out  16  output column = iX_Cont>>1 of completing beat
oY_Cont  out  16  output row = iY_Cont>>1 of completing beat
oDVAL  out  1  one-cycle strobe per emitted RGB pixel

Behaviour:
- Reset (async, iRST=0): oRed/oGreen/oBlue/oGray/oX_Cont/oY_Cont = 0, oDVAL = 0, all pipeline regs 0. Line buffer RAM is not cleared.
- Bayer map by {Y[0],X[0]}: 00=G1, 01=R, 10=B, 11=G2.
- Accepted beat: iDVAL=1 and iX_Cont < COLUMN_WIDTH. Beats with X >= COLUMN_WIDTH are ignored: no write, no output.
- Line buffer: single-port RAM, depth COLUMN_WIDTH, address iX_Cont, read-before-write.
  - On each accepted beat: old word is read (previous row, same X) and iDATA is written.
  - Read data is valid the next cycle.
- Stage 1 (cycle t+1 after beat at t):
  - Registers: current pixel, previous-row pixel, X, Y, and a "complete" flag = accepted & Y[0] & X[0].
  - Holds cur_prev/top_prev registers (pixels from the previous accepted beat in each row). These update only on accepted beats.
- Quad at completion (X odd, Y odd): G1=top_prev, R=top, B=cur_prev, G2=cur.
- Arithmetic:
  - G = (G1+G2)>>1, using a 13-bit sum with truncation.
  - Gray = (R + 2*G + B)>>2, using a 14-bit sum with truncation.
  - No saturation is needed; the results cannot overflow.
- Stage 2 (cycle t+2): the output registers load and oDVAL=1 for exactly one cycle. Latency is fixed at 2 cycles from the completing beat.
- When oDVAL=0, the data outputs hold their last emitted values.
- iDVAL gaps (any length, mid-row or between rows): no effect on results. Pairing uses the last accepted beat, not the previous cycle.
- Even rows and even columns never emit. Output frame size is (COLUMN_WIDTH/2) x (rows/2).
- Frame restart (Y returns to 0): needs no special handling. Row 0 rewrites the buffer before any odd row reads it.
- Reset mid-frame: pipeline is flushed and no strobe comes from pre-reset beats. Stale RAM contents are harmless because every odd row is preceded by its even row.
- Back-to-back accepted beats every cycle are supported. Throughput is 1 pixel/cycle in, 1 quad per 4 beats out.

Decomposition:
- Shared package: DATA_WIDTH and COLUMN_WIDTH defaults; Bayer position enum (G1,R,B,G2) with its {Y[0],X[0]} encoding; the luma weights.
- Sub-module ccd_line_buffer: parameterised single-port read-before-write RAM (DATA_WIDTH x COLUMN_WIDTH), 1-cycle read latency. Kept separate so it can map to an on-chip RAM primitive.

Test Plan:
- COLUMN_WIDTH=4, continuous valid.
  - Stimulus: row0 = 100,200,100,200; row1 = 50,120,50,120.
  - Required: two strobes at Y=1,X=1 and X=3. Each gives R=200, G=110, B=50, Gray=117; oX=0 then 1, oY=0; each strobe exactly 2 cycles after its beat.
- Same stimulus with iDVAL low 3 cycles between every beat -> identical values. Each strobe 2 cycles after its completing beat; no strobes elsewhere.
- All pixels 4095 -> R=G=B=Gray=4095 (no overflow). All pixels 0 -> all zero.
- Beats with iX_Cont=4 or 5 injected (COLUMN_WIDTH=4) -> no RAM write (verify by readback in the next row) and no strobe.
- Reset asserted 1 cycle after a completing beat -> all outputs 0 immediately and no strobe afterwards. A full frame after release reproduces the first scenario's values.
- Two frames back to back with different row0 data -> frame 2 outputs use only frame 2 rows.
